// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard controller for the 5-stage core.
// Generates stall/flush enables for the PC, IF/ID, ID/EX and EX/MEM latches
// from memory stalls, redirects, multi-cycle EX ops and load-use hazards.
// Ports: CLK/RST (async active-high); ihit, dmem_req, dhit (memory handshakes);
//   id_src/id_src_vld (ID operands); ex_load/ex_dest/ex_mc/redirect (EX info);
//   stall_*/flush_* (combinational latch controls); stall_count (cycles with stall_pc).
module hazard_ctrl_unit #(
  parameter int REG_W    = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 1,
  parameter int CNT_W    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ihit,
  input  logic                     dmem_req,
  input  logic                     dhit,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_vld,
  input  logic                     ex_load,
  input  logic [REG_W-1:0]         ex_dest,
  input  logic                     ex_mc,
  input  logic                     redirect,
  output logic                     stall_pc,
  output logic                     stall_ifid,
  output logic                     stall_idex,
  output logic                     stall_exmem,
  output logic                     flush_ifid,
  output logic                     flush_idex,
  output logic                     flush_exmem,
  output logic [CNT_W-1:0]         stall_count
);

  localparam int         SB_N     = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
  localparam logic       MC_MULTI = (MC_LAT > 1);
  // BUSY is entered after the first hold cycle, so it counts the remaining MC_LAT-2.
  localparam logic [4:0] MC_INIT  = (MC_LAT > 1) ? 5'(MC_LAT - 2) : 5'd0;

  typedef enum logic {MC_IDLE, MC_BUSY} mc_state_e;

  mc_state_e          state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               mem_stall;
  logic               mc_hold;
  logic               load_use;
  logic [NUM_SRC-1:0] sb_hit;

  assign mem_stall   = dmem_req & ~dhit;
  assign stall_count = stall_count_q;

  // Hold EX while a multi-cycle op is in flight; a redirect cancels a fresh start.
  always_comb begin
    mc_hold = 1'b0;
    if (state_q == MC_IDLE) mc_hold = ex_mc & MC_MULTI & ~redirect;
    else                    mc_hold = (cnt_q != 5'd0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_stall) begin
      if (state_q == MC_IDLE) begin
        if (mc_hold) begin
          state_d = MC_BUSY;
          cnt_d   = MC_INIT;
        end
      end else if (cnt_q != 5'd0) begin
        cnt_d = cnt_q - 5'd1;
      end else begin
        state_d = MC_IDLE;
      end
    end
  end

  // Loads that have left EX but whose data is not yet forwardable. Entry k
  // holds the load that left EX k+1 advancing cycles ago; invalid entries are
  // shifted in while EX is held so older loads keep aging.
  generate
    if (LOAD_LAT > 1) begin : g_sb
      logic [SB_N-1:0]            sb_vld_q, sb_vld_d;
      logic [SB_N-1:0][REG_W-1:0] sb_dest_q, sb_dest_d;

      always_comb begin
        sb_vld_d  = sb_vld_q;
        sb_dest_d = sb_dest_q;
        if (!mem_stall) begin
          sb_vld_d[0]  = ex_load & (ex_dest != '0) & ~mc_hold;
          sb_dest_d[0] = ex_dest;
          for (int k = 1; k < SB_N; k++) begin
            sb_vld_d[k]  = sb_vld_q[k-1];
            sb_dest_d[k] = sb_dest_q[k-1];
          end
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          sb_vld_q  <= '0;
          sb_dest_q <= '0;
        end else begin
          sb_vld_q  <= sb_vld_d;
          sb_dest_q <= sb_dest_d;
        end
      end

      always_comb begin
        sb_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
          for (int k = 0; k < SB_N; k++) begin
            if (sb_vld_q[k] && (sb_dest_q[k] == id_src[i*REG_W +: REG_W])) sb_hit[i] = 1'b1;
          end
        end
      end
    end else begin : g_no_sb
      assign sb_hit = '0;
    end
  endgenerate

  // r0 is never a real dependency.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_vld[i] && (id_src[i*REG_W +: REG_W] != '0)) begin
        if ((ex_load && (id_src[i*REG_W +: REG_W] == ex_dest)) || sb_hit[i]) load_use = 1'b1;
      end
    end
  end

  // First matching cause wins.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (mem_stall) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
    end else if (redirect) begin
      // PC takes the branch target even when the fetch has not completed.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (mc_hold) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (load_use) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (!ihit) begin
      stall_pc   = 1'b1;
      flush_ifid = 1'b1;
    end
  end

  assign stall_count_d = stall_count_q + CNT_W'(stall_pc);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= MC_IDLE;
      cnt_q         <= 5'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: two hazard_ctrl_unit configurations driven with the
// same inputs, checked against an age-based load list / hold-cycle model.
// Ports: none (top-level bench).
module tb_hazard_ctrl_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dmem_req, dhit, ex_load, ex_mc, redirect;
  logic [9:0] id_src;
  logic [1:0] id_src_vld;
  logic [4:0] ex_dest;

  logic       spc_a, sifid_a, sidex_a, sexmem_a, fifid_a, fidex_a, fexmem_a;
  logic       spc_b, sifid_b, sidex_b, sexmem_b, fifid_b, fidex_b, fexmem_b;
  logic [3:0] stall_count_a;
  logic [5:0] stall_count_b;
  logic [6:0] oa, ob;

  assign oa = {spc_a, sifid_a, sidex_a, sexmem_a, fifid_a, fidex_a, fexmem_a};
  assign ob = {spc_b, sifid_b, sidex_b, sexmem_b, fifid_b, fidex_b, fexmem_b};

  always #5 CLK = ~CLK;

  hazard_ctrl_unit #(.REG_W(5), .NUM_SRC(2), .LOAD_LAT(3), .MC_LAT(4), .CNT_W(4)) dut_a (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .id_src(id_src), .id_src_vld(id_src_vld), .ex_load(ex_load), .ex_dest(ex_dest),
    .ex_mc(ex_mc), .redirect(redirect),
    .stall_pc(spc_a), .stall_ifid(sifid_a), .stall_idex(sidex_a), .stall_exmem(sexmem_a),
    .flush_ifid(fifid_a), .flush_idex(fidex_a), .flush_exmem(fexmem_a),
    .stall_count(stall_count_a));

  hazard_ctrl_unit #(.REG_W(5), .NUM_SRC(2), .LOAD_LAT(1), .MC_LAT(8), .CNT_W(6)) dut_b (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .id_src(id_src), .id_src_vld(id_src_vld), .ex_load(ex_load), .ex_dest(ex_dest),
    .ex_mc(ex_mc), .redirect(redirect),
    .stall_pc(spc_b), .stall_ifid(sifid_b), .stall_idex(sidex_b), .stall_exmem(sexmem_b),
    .flush_ifid(fifid_b), .flush_idex(fidex_b), .flush_exmem(fexmem_b),
    .stall_count(stall_count_b));

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  logic       ld_v [2][8];
  int         ld_a [2][8];
  logic [4:0] ld_d [2][8];
  logic       mc_busy [2];
  int         mc_done [2];
  int         cnt_m [2];
  logic [6:0] exp_o [2];

  function automatic int ll(input int d); return (d == 0) ? 3 : 1; endfunction
  function automatic int ml(input int d); return (d == 0) ? 4 : 8; endfunction
  function automatic int cw(input int d); return (d == 0) ? 4 : 6; endfunction

  function automatic logic mc_hold_m(input int d);
    logic h;
    if (mc_busy[d]) h = (mc_done[d] < ml(d) - 1);
    else            h = ex_mc && (ml(d) > 1) && !redirect;
    return h;
  endfunction

  function automatic logic load_use_m(input int d);
    logic       hit;
    logic [4:0] s;
    hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = id_src[i*5 +: 5];
      if (id_src_vld[i] && s != 5'd0) begin
        if (ex_load && ex_dest == s) hit = 1'b1;
        for (int k = 0; k < 8; k++) if (ld_v[d][k] && ld_d[d][k] == s) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Bits: stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_exmem
  function automatic logic [6:0] model_out(input int d);
    logic [6:0] o;
    if (dmem_req && !dhit)  o = 7'b1111000;
    else if (redirect)      o = 7'b0000110;
    else if (mc_hold_m(d))  o = 7'b1110001;
    else if (load_use_m(d)) o = 7'b1100010;
    else if (!ihit)         o = 7'b1000100;
    else                    o = 7'b0000000;
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        ld_v[d][k] = 1'b0; ld_a[d][k] = 0; ld_d[d][k] = 5'd0;
      end
      mc_busy[d] = 1'b0; mc_done[d] = 0; cnt_m[d] = 0;
    end
  endtask

  task automatic model_update();
    logic h, ins;
    for (int d = 0; d < 2; d++) begin
      cnt_m[d] = (cnt_m[d] + int'(exp_o[d][6])) % (1 << cw(d));
      if (!(dmem_req && !dhit)) begin
        h = mc_hold_m(d);
        for (int k = 0; k < 8; k++) begin
          if (ld_v[d][k]) begin
            ld_a[d][k] = ld_a[d][k] + 1;
            if (ld_a[d][k] >= ll(d)) ld_v[d][k] = 1'b0;
          end
        end
        if (ll(d) > 1 && ex_load && ex_dest != 5'd0 && !h) begin
          ins = 1'b1;
          for (int k = 0; k < 8; k++) begin
            if (ins && !ld_v[d][k]) begin
              ld_v[d][k] = 1'b1; ld_a[d][k] = 1; ld_d[d][k] = ex_dest; ins = 1'b0;
            end
          end
        end
        if (h) begin mc_busy[d] = 1'b1; mc_done[d] = mc_done[d] + 1; end
        else   begin mc_busy[d] = 1'b0; mc_done[d] = 0; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) exp_o[d] = model_out(d);
    chk({tag, "/a_out"}, 32'(oa), 32'(exp_o[0]));
    chk({tag, "/a_cnt"}, 32'(stall_count_a), cnt_m[0]);
    chk({tag, "/b_out"}, 32'(ob), 32'(exp_o[1]));
    chk({tag, "/b_cnt"}, 32'(stall_count_b), cnt_m[1]);
  endtask

  task automatic set_in(input logic ih, input logic dr, input logic dh,
                        input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] v,
                        input logic ld, input logic [4:0] dst, input logic mc, input logic rd);
    ihit = ih; dmem_req = dr; dhit = dh; id_src = {s1, s0}; id_src_vld = v;
    ex_load = ld; ex_dest = dst; ex_mc = mc; redirect = rd;
  endtask

  task automatic idle(); set_in(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0); endtask

  task automatic cyc_begin(input string tag); #3; check_all(tag); endtask
  task automatic cyc_end(); model_update(); @(posedge CLK); #1; endtask

  task automatic rst_assert(input string tag);
    #1 RST = 1'b1;
    #1 model_reset();
    check_all(tag);
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    idle();
    model_reset();
    cyc_begin("reset");
    chk("reset_out_a", 32'(oa), 0);
    chk("reset_cnt_a", 32'(stall_count_a), 0);
    RST = 1'b0;
    cyc_end();

    // LOAD_LAT=1 (dut_b): single-cycle load-use, then clear, then r0 load
    set_in(1, 0, 0, 0, 8, 2'b01, 1, 8, 0, 0);
    cyc_begin("ll1_hit"); chk("ll1_hit_b", 32'(ob), 32'(7'b1100010)); cyc_end();
    set_in(1, 0, 0, 0, 8, 2'b01, 0, 8, 0, 0);
    cyc_begin("ll1_after"); chk("ll1_after_b", 32'(ob), 0); cyc_end();
    repeat (4) begin idle(); cyc_begin("drain"); cyc_end(); end
    set_in(1, 0, 0, 0, 8, 2'b01, 1, 0, 0, 0);
    cyc_begin("ll1_r0"); chk("ll1_r0_b", 32'(ob), 0); chk("ll1_r0_a", 32'(oa), 0); cyc_end();

    // LOAD_LAT=3 (dut_a): 3 stall cycles, then 4 with one mem_stall inside
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c <= 3 + r; c++) begin
        set_in(1, (r == 1 && c == 1), 0, 0, 9, 2'b01, (c == 0), 9, 0, 0);
        cyc_begin("ll3");
        chk($sformatf("ll3_r%0d_c%0d_a", r, c), 32'(oa),
            (r == 1 && c == 1) ? 32'(7'b1111000) : (c < 3 + r) ? 32'(7'b1100010) : 0);
        cyc_end();
      end
      repeat (4) begin idle(); cyc_begin("drain"); cyc_end(); end
    end

    // MC_LAT=4 (dut_a): hold 3 cycles, then 4 with one mem_stall inside
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c <= 3 + r; c++) begin
        set_in(1, (r == 1 && c == 1), 0, 0, 0, 2'b00, 0, 0, 1, 0);
        cyc_begin("mc4");
        chk($sformatf("mc4_r%0d_c%0d_a", r, c), 32'(oa),
            (r == 1 && c == 1) ? 32'(7'b1111000) : (c < 3 + r) ? 32'(7'b1110001) : 0);
        cyc_end();
      end
      repeat (9) begin idle(); cyc_begin("drain"); cyc_end(); end
    end

    // mem_stall beats redirect; once data returns, redirect flushes
    set_in(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc_begin("ms_redir"); chk("ms_redir_a", 32'(oa), 32'(7'b1111000)); cyc_end();
    set_in(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc_begin("redir"); chk("redir_a", 32'(oa), 32'(7'b0000110)); cyc_end();

    // stall_count wrap on a 4-bit counter
    idle(); cyc_begin("pre_wrap"); rst_assert("wrap_rst"); RST = 1'b0; cyc_end();
    for (int i = 0; i < 18; i++) begin
      set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      cyc_begin("wrap");
      chk($sformatf("wrap_cnt_%0d", i), 32'(stall_count_a), i % 16);
      cyc_end();
    end
    set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc_begin("redir_nohit"); chk("redir_nohit_a", 32'(oa), 32'(7'b0000110)); cyc_end();
    idle();
    cyc_begin("redir_nocnt"); chk("redir_nocnt_a", 32'(stall_count_a), 2); cyc_end();

    // MC_LAT=8 (dut_b): async reset in BUSY cycle 3
    for (int c = 0; c < 3; c++) begin
      set_in(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0); cyc_begin("mc8"); cyc_end();
    end
    idle();
    cyc_begin("mc8_c3");
    chk("mc8_busy3_b", 32'(ob), 32'(7'b1110001));
    rst_assert("mc8_rst");
    chk("mc8_rst_b", 32'(ob), 0);
    chk("mc8_rst_cnt_b", 32'(stall_count_b), 0);
    RST = 1'b0;
    cyc_end();

    // Scoreboard cleared by reset (dut_a)
    set_in(1, 0, 0, 0, 0, 2'b00, 1, 9, 0, 0); cyc_begin("sb_ld"); cyc_end();
    set_in(1, 0, 0, 0, 9, 2'b01, 0, 0, 0, 0);
    cyc_begin("sb_pre"); chk("sb_pre_a", 32'(oa), 32'(7'b1100010));
    rst_assert("sb_rst"); RST = 1'b0; cyc_end();
    cyc_begin("sb_post"); chk("sb_post_a", 32'(oa), 0); cyc_end();

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      cyc_begin("rnd");
      if ($urandom_range(0, 49) == 0) begin
        rst_assert("rnd_rst");
        RST = 1'b0;
      end
      cyc_end();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
